// File: rtl/count_serializer_if.sv
// ============================================================================
// Module      : count_serializer_if
// Description : Capture request, serial link and FIFO status bundle for the
//               counter snapshot serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface count_serializer_if #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic            sample_i;
  logic [BITS-1:0] count_i;
  logic            en_i;
  logic            overflow_clr_i;
  logic            ser_data_o;
  logic            ser_valid_o;
  logic            ser_frame_o;
  logic            busy_o;
  logic            fifo_empty_o;
  logic            fifo_full_o;
  logic [LW-1:0]   level_o;
  logic            overflow_o;

  // Driving side: counter logic / host.
  modport master (
    output sample_i, count_i, en_i, overflow_clr_i,
    input  ser_data_o, ser_valid_o, ser_frame_o, busy_o,
    input  fifo_empty_o, fifo_full_o, level_o, overflow_o
  );

  // Serializer side.
  modport slave (
    input  sample_i, count_i, en_i, overflow_clr_i,
    output ser_data_o, ser_valid_o, ser_frame_o, busy_o,
    output fifo_empty_o, fifo_full_o, level_o, overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/count_serializer.sv
// ============================================================================
// Module      : count_serializer
// Description : Snapshots the counter into a small FIFO on request and shifts
//               each snapshot out MSB-first with valid / frame-start strobes.
//               Optional macro SERIALIZER_PARITY_EN appends an even-parity bit
//               period to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_serializer #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4,
  parameter int DIV   = 1
) (
  input  logic               clk,
  input  logic               reset,
  count_serializer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = BITS + 1;
`else
  localparam int FRAME_BITS = BITS;
`endif
  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(FRAME_BITS - 1);
  localparam logic [DCW-1:0] DIV_LAST   = DCW'(DIV - 1);
  localparam logic [LW-1:0]  LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;

  // Frame engine
  state_t          state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]  div_cnt_q, div_cnt_d;

  // Registered serial outputs
  logic            data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_q, frame_d;
  logic            busy_q, busy_d;

  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_full;

  // A pop only happens when the engine is idle and a frame may start; a push
  // into a full FIFO is still legal when that same cycle frees an entry.
  always_comb begin
    w_full = (level_q == LEVEL_FULL);
    w_pop  = (state_q == IDLE) && bus.en_i && (level_q != '0);
    w_push = bus.sample_i && (!w_full || w_pop);
    w_drop = bus.sample_i && w_full && !w_pop;
  end

  // Next FIFO pointers, occupancy, flags and sticky overflow (set beats clear).
  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (w_push && !w_pop) begin
      level_d = level_q + LW'(1);
    end else if (w_pop && !w_push) begin
      level_d = level_q - LW'(1);
    end
    empty_d    = (level_d == '0);
    full_d     = (level_d == LEVEL_FULL);
    overflow_d = overflow_q;
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  // Snapshot storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.count_i;
    end
  end

  // Frame sequencing: load on pop, shift every DIV cycles, one gap cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      IDLE: begin
        if (w_pop) begin
          state_d   = SHIFT;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          shift_d   = {shift_q[BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = GAP;
          end
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SERIALIZER_PARITY_EN
  logic parity_q, parity_d;

  // Even parity of the word being sent, captured as it leaves the FIFO.
  always_comb begin
    parity_d = w_pop ? ^mem_q[rd_ptr_q] : parity_q;
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // Output values for the next cycle; the bit after the data carries parity.
  always_comb begin
    valid_d = (state_d == SHIFT);
    frame_d = valid_d && (bit_cnt_d == '0);
    busy_d  = (state_d != IDLE);
    if (bit_cnt_d == BCW'(BITS)) begin
      data_d = valid_d && parity_d;
    end else begin
      data_d = valid_d && shift_d[BITS-1];
    end
  end
`else
  // Output values for the next cycle, derived from the next engine state.
  always_comb begin
    valid_d = (state_d == SHIFT);
    frame_d = valid_d && (bit_cnt_d == '0);
    busy_d  = (state_d != IDLE);
    data_d  = valid_d && shift_d[BITS-1];
  end
`endif

  // State, FIFO bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ser_data_o   = data_q;
  assign bus.ser_valid_o  = valid_q;
  assign bus.ser_frame_o  = frame_q;
  assign bus.busy_o       = busy_q;
  assign bus.fifo_empty_o = empty_q;
  assign bus.fifo_full_o  = full_q;
  assign bus.level_o      = level_q;
  assign bus.overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_count_serializer.sv
// ============================================================================
// Module      : tb_count_serializer
// Description : Self-checking bench for count_serializer: two instances
//               (DIV=1 and DIV=3) share one stimulus stream and are each
//               compared every cycle against a queue-based frame model.
//               Honours SERIALIZER_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_serializer;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int FB = BITS + 1;
`else
  localparam int FB = BITS;
`endif
  localparam int PAR = FB - BITS;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        sample = 1'b0;
  logic        en     = 1'b0;
  logic        clr    = 1'b0;
  logic [31:0] count  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  count_serializer_if #(.BITS(BITS), .DEPTH(DEPTH)) bus0 ();
  count_serializer_if #(.BITS(BITS), .DEPTH(DEPTH)) bus1 ();

  assign bus0.sample_i       = sample;
  assign bus0.count_i        = count;
  assign bus0.en_i           = en;
  assign bus0.overflow_clr_i = clr;
  assign bus1.sample_i       = sample;
  assign bus1.count_i        = count;
  assign bus1.en_i           = en;
  assign bus1.overflow_clr_i = clr;

  count_serializer #(.BITS(BITS), .DEPTH(DEPTH), .DIV(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  count_serializer #(.BITS(BITS), .DEPTH(DEPTH), .DIV(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 sending frame (tpos = cycle index inside frame), 2 gap
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int          mode[2];
  int          tpos[2];
  logic [31:0] word[2];
  logic        movf[2];
  bit          armed = 0;

  function automatic int divk(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic exp_data(input int k);
    int b;
    if (mode[k] != 1) return 1'b0;
    b = tpos[k] / divk(k);
    if (b < BITS) return word[k][BITS-1-b];
    return ^word[k];
  endfunction

  task automatic model_step(input int k);
    bit pop, full, push, drop;
    if (reset) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      mode[k] = 0;
      tpos[k] = 0;
      movf[k] = 1'b0;
      return;
    end
    pop  = (mode[k] == 0) && en && (qsize(k) > 0);
    full = (qsize(k) == DEPTH);
    push = sample && (!full || pop);
    drop = sample && full && !pop;
    if (mode[k] == 1) begin
      tpos[k]++;
      if (tpos[k] == FB * divk(k)) mode[k] = 2;
    end else if (mode[k] == 2) begin
      mode[k] = 0;
    end else if (pop) begin
      if (k == 0) word[k] = mq0.pop_front();
      else        word[k] = mq1.pop_front();
      mode[k] = 1;
      tpos[k] = 0;
    end
    if (push) begin
      if (k == 0) mq0.push_back(count);
      else        mq1.push_back(count);
    end
    if (drop)     movf[k] = 1'b1;
    else if (clr) movf[k] = 1'b0;
  endtask

  task automatic compare_outputs(input int k);
    logic       d, v, f, b, e, fu, o;
    logic [2:0] l;
    if (k == 0) begin
      d = bus0.ser_data_o; v = bus0.ser_valid_o; f = bus0.ser_frame_o; b = bus0.busy_o;
      e = bus0.fifo_empty_o; fu = bus0.fifo_full_o; l = bus0.level_o; o = bus0.overflow_o;
    end else begin
      d = bus1.ser_data_o; v = bus1.ser_valid_o; f = bus1.ser_frame_o; b = bus1.busy_o;
      e = bus1.fifo_empty_o; fu = bus1.fifo_full_o; l = bus1.level_o; o = bus1.overflow_o;
    end
    check("m_valid", k, 32'(v), 32'(mode[k] == 1));
    check("m_data",  k, 32'(d), 32'(exp_data(k)));
    check("m_frame", k, 32'(f), 32'((mode[k] == 1) && (tpos[k] < divk(k))));
    check("m_busy",  k, 32'(b), 32'(mode[k] != 0));
    check("m_level", k, 32'(l), 32'(qsize(k)));
    check("m_empty", k, 32'(e), 32'(qsize(k) == 0));
    check("m_full",  k, 32'(fu), 32'(qsize(k) == DEPTH));
    check("m_ovf",   k, 32'(o), 32'(movf[k]));
  endtask

  // Compare last edge's outputs, then advance the model for the next edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) compare_outputs(k);
    end
    for (int k = 0; k < 2; k++) model_step(k);
    if (reset) armed = 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Push one value with en high and observe both instances for a full frame.
  task automatic run_frame(input logic [31:0] val, output logic [31:0] bits0,
                           output int v0, output int f0, output int ones0,
                           output int v1, output int f1, output int ones1);
    bits0 = '0; v0 = 0; f0 = 0; ones0 = 0; v1 = 0; f1 = 0; ones1 = 0;
    sample = 1'b1; count = val; en = 1'b1;
    tick();
    sample = 1'b0;
    check("cap_level", 0, 32'(bus0.level_o), 32'd1);
    for (int i = 0; i < 115; i++) begin
      tick();
      if (bus0.ser_valid_o) begin
        if (v0 < BITS) bits0 = {bits0[30:0], bus0.ser_data_o};
        v0++;
        ones0 += int'(bus0.ser_data_o);
      end
      f0 += int'(bus0.ser_frame_o);
      if (bus1.ser_valid_o) begin
        v1++;
        ones1 += int'(bus1.ser_data_o);
      end
      f1 += int'(bus1.ser_frame_o);
    end
    check("frm_level0", 0, 32'(bus0.level_o), 32'd0);
    check("frm_level1", 1, 32'(bus1.level_o), 32'd0);
  endtask

  initial begin
    logic [31:0] bits0, acc;
    logic [31:0] got[$];
    int v0, f0, o0, v1, f1, o1, n, seen;

    reset = 1'b1;
    tick();
    tick();
    check("rst_empty", 0, 32'(bus0.fifo_empty_o), 32'd1);
    check("rst_level", 0, 32'(bus0.level_o), 32'd0);
    check("rst_valid", 1, 32'(bus1.ser_valid_o), 32'd0);
    check("rst_busy",  1, 32'(bus1.busy_o), 32'd0);
    reset = 1'b0;

    // Single frames with literal expectations.
    run_frame(32'hA5000001, bits0, v0, f0, o0, v1, f1, o1);
    check("a5_bits",   0, bits0, 32'hA5000001);
    check("a5_frame0", 0, 32'(f0), 32'd1);
    check("a5_valid0", 0, 32'(v0), 32'(FB));
    check("a5_valid1", 1, 32'(v1), 32'(FB * 3));
    check("a5_frame1", 1, 32'(f1), 32'd3);

    run_frame(32'h80000000, bits0, v0, f0, o0, v1, f1, o1);
    check("msb_ones0", 0, 32'(o0), 32'(1 + PAR));
    check("msb_ones1", 1, 32'(o1), 32'(3 * (1 + PAR)));
    check("msb_valid1", 1, 32'(v1), 32'(FB * 3));

    run_frame(32'h00000007, bits0, v0, f0, o0, v1, f1, o1);
    check("seven_ones0", 0, 32'(o0), 32'(3 + PAR));
    check("seven_bits",  0, bits0, 32'h00000007);

    // Overflow: five samples into a four-entry FIFO with the engine held off.
    en = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      sample = 1'b1; count = 32'(v);
      tick();
    end
    sample = 1'b0;
    check("ovf_level", 0, 32'(bus0.level_o), 32'd4);
    check("ovf_full",  1, 32'(bus1.fifo_full_o), 32'd1);
    check("ovf_flag",  0, 32'(bus0.overflow_o), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_clr", 1, 32'(bus1.overflow_o), 32'd0);
    // Full FIFO: pop and push in the same cycle.
    en = 1'b1; sample = 1'b1; count = 32'd6;
    tick();
    sample = 1'b0;
    check("pp_level", 0, 32'(bus0.level_o), 32'd4);
    check("pp_ovf",   1, 32'(bus1.overflow_o), 32'd0);
    acc = '0; n = 0;
    for (int i = 0; i < 520; i++) begin
      if (bus0.ser_frame_o) begin
        acc = '0; n = 0;
      end
      if (bus0.ser_valid_o && n < BITS) begin
        acc = {acc[30:0], bus0.ser_data_o};
        n++;
        if (n == BITS) got.push_back(acc);
      end
      tick();
    end
    check("order_cnt", 0, 32'(got.size()), 32'd5);
    if (got.size() == 5) begin
      check("order_w0", 0, got[0], 32'd1);
      check("order_w1", 0, got[1], 32'd2);
      check("order_w2", 0, got[2], 32'd3);
      check("order_w3", 0, got[3], 32'd4);
      check("order_w4", 0, got[4], 32'd6);
    end

    // Reset in the middle of a frame with two entries still queued.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample = 1'b1; count = $urandom();
      tick();
    end
    sample = 1'b0; en = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 10; i++) begin
      tick();
      seen += int'(bus0.ser_valid_o);
    end
    check("mid_reach", 0, 32'(seen), 32'd10);
    reset = 1'b1;
    tick();
    check("mid_valid", 0, 32'(bus0.ser_valid_o), 32'd0);
    check("mid_level", 0, 32'(bus0.level_o), 32'd0);
    check("mid_empty", 1, 32'(bus1.fifo_empty_o), 32'd1);
    check("mid_busy",  0, 32'(bus0.busy_o), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen += int'(bus0.ser_valid_o) + int'(bus1.ser_valid_o);
    end
    check("mid_silent", 0, 32'(seen), 32'd0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      sample = ($urandom_range(0, 9) == 0);
      count  = $urandom();
      en     = ((i % 400) < 300) ? ($urandom_range(0, 7) != 0) : 1'b0;
      clr    = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 599) == 0);
      tick();
    end
    sample = 1'b0; clr = 1'b0; reset = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
